// File: rtl/tdm_pkg.sv
// Shared definitions for the two-channel TDM demultiplexer: FSM state
// encoding, default word width and slot-counter sizing.
package tdm_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // A frame has 2*w slots; the counter must index slots 0 .. 2*w-1.
    function automatic int slot_width(input int w);
        return (w < 1) ? 1 : $clog2(2 * w);
    endfunction

endpackage

// File: rtl/demux_shift.sv
// W-bit LSB-first shift register for one channel. "word" is the value the
// register takes at the next edge, so the owner can capture a word whose
// final bit arrives in the same cycle.
module demux_shift
    import tdm_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         d,
    output logic [W-1:0] word
);

    logic [W-1:0] q;
    logic [W-1:0] base;

    // The clear takes effect before the shift, so a frame-start bit lands
    // in a freshly emptied register.
    always_comb begin
        base = clr ? '0 : q;
        word = base;
        if (en) begin
            word = (base >> 1) | (W'(d) << (W - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= word;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Two-channel bit-interleaved TDM demultiplexer: even slots feed ch0, odd
// slots feed ch1, LSB first; a sync arriving mid-frame restarts the frame.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic         sync,
    output logic [W-1:0] ch0,
    output logic [W-1:0] ch1,
    output logic         valid,
    output logic         frame_err
);

    localparam int CW = slot_width(W);
    localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          capture;
    logic          slot_odd;
    logic          clr_frame;
    logic          load;
    logic          err_d;
    logic          en0;
    logic          en1;
    logic [W-1:0]  word0;
    logic [W-1:0]  word1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        capture   = 1'b0;
        slot_odd  = 1'b0;
        clr_frame = 1'b0;
        load      = 1'b0;
        err_d     = 1'b0;
        case (state)
            IDLE: begin
                if (sync) begin
                    capture   = 1'b1;
                    clr_frame = 1'b1;
                    cnt_n     = CW'(1);
                    state_n   = RECV;
                end
            end
            RECV: begin
                capture = 1'b1;
                if (sync) begin
                    // Restart: this cycle becomes slot 0 of a new frame.
                    clr_frame = 1'b1;
                    err_d     = 1'b1;
                    cnt_n     = CW'(1);
                end else begin
                    slot_odd = cnt[0];
                    if (cnt == LAST) begin
                        load    = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign en0 = capture & ~slot_odd;
    assign en1 = capture & slot_odd;

    demux_shift #(.W(W)) u_shift0 (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_frame),
        .en   (en0),
        .d    (din),
        .word (word0)
    );

    demux_shift #(.W(W)) u_shift1 (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_frame),
        .en   (en1),
        .d    (din),
        .word (word1)
    );

    // Outputs change only on a completed frame, so no partial word is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ch0       <= '0;
            ch1       <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            valid     <= load;
            frame_err <= err_d;
            if (load) begin
                ch0 <= word0;
                ch1 <= word1;
            end
        end
    end

    a_no_coincide: assert property (@(posedge clk) disable iff (rst)
        !(valid && frame_err));

    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt <= LAST);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (W=4): directed scenarios plus random
// frames compared against a bit-list reference model.
module tb_tdm_demux;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] ch0;
    logic [W-1:0] ch1;
    logic         valid;
    logic         frame_err;

    tdm_demux #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sync      (sync),
        .ch0       (ch0),
        .ch1       (ch1),
        .valid     (valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: collected bits of the frame in progress.
    logic [2*W-1:0] exp_q[$];
    bit             frame_bits[$];
    bit             in_frame = 1'b0;
    logic           m_valid = 1'b0;
    logic           m_err = 1'b0;
    logic [W-1:0]   m_ch0 = '0;
    logic [W-1:0]   m_ch1 = '0;

    // Apply one cycle of inputs, wait past the edge, then advance the model
    // to predict what the outputs show now.
    task automatic step(input logic r, input logic s, input logic d);
        rst  = r;
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            frame_bits.delete();
            in_frame = 1'b0;
            m_ch0    = '0;
            m_ch1    = '0;
        end else begin
            if (s) begin
                if (in_frame) m_err = 1'b1;
                frame_bits.delete();
                frame_bits.push_back(d);
                in_frame = 1'b1;
            end else if (in_frame) begin
                frame_bits.push_back(d);
            end
            if (in_frame && frame_bits.size() == 2 * W) begin
                for (int i = 0; i < W; i++) begin
                    m_ch0[i] = frame_bits[2*i];
                    m_ch1[i] = frame_bits[2*i+1];
                end
                m_valid  = 1'b1;
                in_frame = 1'b0;
                exp_q.push_back({m_ch1, m_ch0});
            end
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if ({valid, frame_err, ch0, ch1} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%b err=%b ch0=%h ch1=%h, want all 0",
                     valid, frame_err, ch0, ch1);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] pat;
        pat = 8'b0011_1001;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, i == 0, pat[i]);
            if (i < 7) begin
                n_cmp++;
                if (valid !== 1'b0 || ch0 !== 4'h0 || ch1 !== 4'h0) begin
                    n_bad++;
                    $display("FAIL single_early_out: cycle %0d valid=%b ch0=%h ch1=%h, want 0/0/0",
                             i + 1, valid, ch0, ch1);
                end
            end
        end
        n_cmp++;
        if (valid !== 1'b1 || frame_err !== 1'b0 || ch0 !== 4'b0101 || ch1 !== 4'b0110) begin
            n_bad++;
            $display("FAIL single_decode: valid=%b err=%b ch0=%b ch1=%b, want 1 0 0101 0110",
                     valid, frame_err, ch0, ch1);
        end
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (valid !== 1'b0 || ch0 !== 4'b0101 || ch1 !== 4'b0110) begin
            n_bad++;
            $display("FAIL single_hold: valid=%b ch0=%b ch1=%b, want 0 0101 0110",
                     valid, ch0, ch1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        logic [3:0] e0;
        logic [3:0] e1;
        r = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            e0[k] = r[2*k];
            e1[k] = r[2*k+1];
        end
        for (int i = 0; i < 8; i++) step(1'b0, i == 0, r[i]);
        n_cmp++;
        if (valid !== 1'b1 || ch0 !== e0 || ch1 !== e1) begin
            n_bad++;
            $display("FAIL b2b_first: valid=%b ch0=%h ch1=%h, want 1 %h %h", valid, ch0, ch1, e0, e1);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, i == 0, 1'b1);
            if (i < 7) begin
                n_cmp++;
                if (valid !== 1'b0 || frame_err !== 1'b0 || ch0 !== e0 || ch1 !== e1) begin
                    n_bad++;
                    $display("FAIL b2b_gap: slot %0d valid=%b err=%b ch0=%h ch1=%h, want 0 0 %h %h",
                             i, valid, frame_err, ch0, ch1, e0, e1);
                end
            end
        end
        n_cmp++;
        if (valid !== 1'b1 || ch0 !== 4'hF || ch1 !== 4'hF) begin
            n_bad++;
            $display("FAIL b2b_second: valid=%b ch0=%h ch1=%h, want 1 f f", valid, ch0, ch1);
        end
    endtask

    task automatic test_early_sync();
        logic [3:0] p0;
        logic [3:0] p1;
        logic [7:0] nb;
        logic [3:0] e0;
        logic [3:0] e1;
        p0 = ch0;
        p1 = ch1;
        nb = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            e0[k] = nb[2*k];
            e1[k] = nb[2*k+1];
        end
        step(1'b0, 1'b1, 1'($urandom));
        step(1'b0, 1'b0, 1'($urandom));
        step(1'b0, 1'b0, 1'($urandom));
        step(1'b0, 1'b1, nb[0]);
        n_cmp++;
        if (frame_err !== 1'b1 || valid !== 1'b0 || ch0 !== p0 || ch1 !== p1) begin
            n_bad++;
            $display("FAIL early_err: err=%b valid=%b ch0=%h ch1=%h, want 1 0 %h %h",
                     frame_err, valid, ch0, ch1, p0, p1);
        end
        for (int c = 4; c <= 10; c++) begin
            step(1'b0, 1'b0, nb[c-3]);
            if (c < 10) begin
                n_cmp++;
                if (valid !== 1'b0 || frame_err !== 1'b0 || ch0 !== p0 || ch1 !== p1) begin
                    n_bad++;
                    $display("FAIL early_hold: cycle %0d valid=%b err=%b ch0=%h ch1=%h, want 0 0 %h %h",
                             c + 1, valid, frame_err, ch0, ch1, p0, p1);
                end
            end
        end
        n_cmp++;
        if (valid !== 1'b1 || frame_err !== 1'b0 || ch0 !== e0 || ch1 !== e1) begin
            n_bad++;
            $display("FAIL early_decode: valid=%b err=%b ch0=%h ch1=%h, want 1 0 %h %h",
                     valid, frame_err, ch0, ch1, e0, e1);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] nb;
        logic [3:0] e0;
        logic [3:0] e1;
        step(1'b0, 1'b1, 1'b1);
        for (int c = 1; c < 5; c++) step(1'b0, 1'b0, 1'($urandom));
        step(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if ({valid, frame_err, ch0, ch1} !== '0) begin
            n_bad++;
            $display("FAIL midrst_clear: valid=%b err=%b ch0=%h ch1=%h, want all 0",
                     valid, frame_err, ch0, ch1);
        end
        for (int c = 6; c < 12; c++) begin
            step(1'b0, 1'b0, 1'($urandom));
            n_cmp++;
            if ({valid, frame_err, ch0, ch1} !== '0) begin
                n_bad++;
                $display("FAIL midrst_quiet: cycle %0d valid=%b err=%b ch0=%h ch1=%h, want all 0",
                         c + 1, valid, frame_err, ch0, ch1);
            end
        end
        nb = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            e0[k] = nb[2*k];
            e1[k] = nb[2*k+1];
        end
        for (int i = 0; i < 8; i++) step(1'b0, i == 0, nb[i]);
        n_cmp++;
        if (valid !== 1'b1 || ch0 !== e0 || ch1 !== e1) begin
            n_bad++;
            $display("FAIL midrst_decode: valid=%b ch0=%h ch1=%h, want 1 %h %h", valid, ch0, ch1, e0, e1);
        end
    endtask

    task automatic test_idle_noise();
        logic [3:0] p0;
        logic [3:0] p1;
        step(1'b0, 1'b0, 1'b0);
        p0 = ch0;
        p1 = ch1;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, c[0]);
            n_cmp++;
            if (valid !== 1'b0 || frame_err !== 1'b0 || ch0 !== p0 || ch1 !== p1) begin
                n_bad++;
                $display("FAIL idle_noise: cycle %0d valid=%b err=%b ch0=%h ch1=%h, want 0 0 %h %h",
                         c, valid, frame_err, ch0, ch1, p0, p1);
            end
        end
    endtask

    task automatic test_random();
        logic       s;
        logic       r;
        logic [7:0] got;
        logic [7:0] want;
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 199) == 0);
            if (in_frame) s = ($urandom_range(0, 11) == 0);
            else          s = ($urandom_range(0, 2) != 0);
            step(r, s, 1'($urandom));
            n_cmp++;
            if (valid !== m_valid || frame_err !== m_err || ch0 !== m_ch0 || ch1 !== m_ch1) begin
                n_bad++;
                $display("FAIL rand_cycle: cycle %0d valid=%b err=%b ch0=%h ch1=%h, want %b %b %h %h",
                         c, valid, frame_err, ch0, ch1, m_valid, m_err, m_ch0, m_ch1);
            end
            n_cmp++;
            if (valid === 1'b1 && frame_err === 1'b1) begin
                n_bad++;
                $display("FAIL rand_coincide: cycle %0d valid=%b err=%b, want not both 1",
                         c, valid, frame_err);
            end
            if (valid === 1'b1) begin
                n_cmp++;
                got = {ch1, ch0};
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_sb_extra: cycle %0d got %h, want no word", c, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL rand_sb_word: cycle %0d got %h, want %h", c, got, want);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rand_sb_missing: %0d words left, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_early_sync();
        test_reset_mid_frame();
        test_idle_noise();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
